// File: rtl/rr_ppe_sched.sv
// Round-robin scheduler that hands a request snapshot and priority pointer
// to an external priority encoder (PPE) and turns its answer into a grant.
module rr_ppe_sched #(
    parameter int PPE_LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1023:0] req_vec,
    input  logic          ptr_load_valid,
    input  logic [9:0]    ptr_load_val,
    output logic          ptr_load_ready,
    output logic [1023:0] ppe_req,
    output logic [9:0]    ppe_p_enc,
    input  logic [9:0]    ppe_value,
    input  logic [9:0]    ppe_value_inc,
    input  logic          ppe_valid,
    output logic          grant_valid,
    output logic [9:0]    grant_idx,
    input  logic          grant_ready,
    output logic          busy,
    output logic [31:0]   grant_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        GRANT,
        HOLD
    } state_t;

    localparam logic [3:0] LAST = 4'(PPE_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [9:0] ptr;
    logic [9:0] nxt_ptr;
    logic [3:0] wait_cnt;
    logic       start;
    logic       sample;
    logic       accept;

    assign start          = en && (|req_vec);
    assign sample         = (state == WAIT) && (wait_cnt == LAST);
    assign accept         = (state == GRANT) && grant_ready;
    assign busy           = (state != IDLE);
    assign ptr_load_ready = (state == IDLE);
    assign grant_valid    = (state == GRANT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (sample) state_nxt = ppe_valid ? GRANT : IDLE;
            GRANT: if (grant_ready) state_nxt = HOLD;
            HOLD:  state_nxt = start ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot reads ptr before any same-edge load lands, so it sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            nxt_ptr   <= '0;
            wait_cnt  <= '0;
            ppe_req   <= '0;
            ppe_p_enc <= '0;
            grant_idx <= '0;
            grant_cnt <= '0;
        end else begin
            if (start && (state == IDLE || state == HOLD)) begin
                ppe_req   <= req_vec;
                ppe_p_enc <= ptr;
            end
            if (ptr_load_valid && state == IDLE) begin
                ptr <= ptr_load_val;
            end else if (accept) begin
                ptr <= nxt_ptr;
            end
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (sample && ppe_valid) begin
                grant_idx <= ppe_value;
                nxt_ptr   <= ppe_value_inc;
            end
            if (accept && grant_cnt != '1) begin
                grant_cnt <= grant_cnt + 32'd1;
            end
        end
    end

endmodule
